// File: rtl/audio_pkg.sv
// Shared types and constants for the voice recorder sample sequencer.
// Latency: n/a | backpressure: n/a.
package audio_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Half-scale code: silence for the unsigned PWM stage.
  function automatic int unsigned mid_level(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/rec_play_ctrl_if.sv
// Control, sample and memory signals of the record/playback sequencer.
// Latency: n/a | backpressure: none, all strobes are fire-and-forget.
interface rec_play_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic [1:0]        slot_sel;
  logic              record_pulse;
  logic              play_pulse;
  logic [DATA_W-1:0] sample_in;
  logic              sample_in_valid;
  logic              sample_tick;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] sample_out;
  logic              sample_out_valid;
  logic [1:0]        state_code;
  logic [1:0]        active_slot;
  logic              done;

  modport master (
    input  slot_sel, record_pulse, play_pulse, sample_in, sample_in_valid,
           sample_tick, mem_rdata,
    output mem_addr, mem_wdata, mem_en, mem_we, sample_out, sample_out_valid,
           state_code, active_slot, done
  );

  modport slave (
    output slot_sel, record_pulse, play_pulse, sample_in, sample_in_valid,
           sample_tick, mem_rdata,
    input  mem_addr, mem_wdata, mem_en, mem_we, sample_out, sample_out_valid,
           state_code, active_slot, done
  );
endinterface

// File: rtl/slot_len_table.sv
// Per-slot recorded length store: one write port, one combinational read port.
// Latency: write visible next cycle | backpressure: none.
module slot_len_table
  import audio_pkg::*;
#(
  parameter int LEN_W = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       wr_slot,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             we,
  input  logic [1:0]       rd_slot,
  output logic [LEN_W-1:0] rd_len
);

  logic [LEN_W-1:0] len_q [NUM_SLOTS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else if (we) begin
      len_q[wr_slot] <= wr_len;
    end
  end

  assign rd_len = len_q[rd_slot];

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer over a slotted single-port sample memory.
// Latency: writes same cycle as strobe, tick-to-sample 2 edges | backpressure: none.
module rec_play_ctrl
  import audio_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input logic             clock,
  input logic             reset,
  rec_play_ctrl_if.master bus
);

  localparam int OFF_W = ADDR_W - 2;
  localparam int LEN_W = OFF_W + 1;
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_level(DATA_W));

  state_t            state;
  logic [OFF_W-1:0]  offset;
  logic [1:0]        slot;
  logic              rd_pend;
  logic [DATA_W-1:0] smp_out;
  logic              smp_vld;
  logic              done_q;

  logic              wr_go, rd_go, rec_stop, play_last;
  logic [LEN_W-1:0]  cur_len, next_cnt;

  assign wr_go = (state == ST_REC) && bus.sample_in_valid;
  assign rd_go = (state == ST_PLAY) && bus.sample_tick && !bus.play_pulse;

  // Samples written including this cycle's; reaches SLOT_DEPTH on the full write.
  assign next_cnt  = {1'b0, offset} + LEN_W'(wr_go);
  assign rec_stop  = (state == ST_REC) && ((wr_go && (&offset)) || bus.record_pulse);
  assign play_last = (({1'b0, offset} + LEN_W'(1)) == cur_len);

  slot_len_table #(.LEN_W(LEN_W)) u_len (
    .clock   (clock),
    .reset   (reset),
    .wr_slot (slot),
    .wr_len  (next_cnt),
    .we      (rec_stop),
    .rd_slot ((state == ST_IDLE) ? bus.slot_sel : slot),
    .rd_len  (cur_len)
  );

  assign bus.mem_en           = wr_go || rd_go;
  assign bus.mem_we           = wr_go;
  assign bus.mem_addr         = (wr_go || rd_go) ? {slot, offset} : '0;
  assign bus.mem_wdata        = wr_go ? bus.sample_in : '0;
  assign bus.sample_out       = smp_out;
  assign bus.sample_out_valid = smp_vld;
  assign bus.state_code       = state;
  assign bus.active_slot      = slot;
  assign bus.done             = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      offset  <= '0;
      slot    <= '0;
      rd_pend <= 1'b0;
      smp_out <= MID;
      smp_vld <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      smp_vld <= 1'b0;
      done_q  <= 1'b0;
      rd_pend <= rd_go;
      case (state)
        ST_IDLE: begin
          smp_out <= MID;
          if (bus.record_pulse) begin
            slot   <= bus.slot_sel;
            offset <= '0;
            state  <= ST_REC;
          end else if (bus.play_pulse && (cur_len != '0)) begin
            slot   <= bus.slot_sel;
            offset <= '0;
            state  <= ST_PLAY;
          end
        end
        ST_REC: begin
          if (rec_stop) begin
            done_q <= 1'b1;
            offset <= '0;
            state  <= ST_IDLE;
          end else if (wr_go) begin
            offset <= offset + 1'b1;
          end
        end
        ST_PLAY: begin
          // A stop discards any read still in flight.
          if (bus.play_pulse) begin
            smp_out <= MID;
            done_q  <= 1'b1;
            rd_pend <= 1'b0;
            offset  <= '0;
            state   <= ST_IDLE;
          end else if (rd_pend) begin
            smp_out <= bus.mem_rdata;
            smp_vld <= 1'b1;
            if (play_last) begin
              done_q <= 1'b1;
              offset <= '0;
              state  <= ST_IDLE;
            end else begin
              offset <= offset + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl with a behavioural single-port BRAM.
module tb_rec_play_ctrl;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic clock;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  logic [DATA_W-1:0] mem_model [64];

  rec_play_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rec_play_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_addr];
    end
  end

  task automatic clear_inputs;
    bus.slot_sel        = 2'd0;
    bus.record_pulse    = 1'b0;
    bus.play_pulse      = 1'b0;
    bus.sample_in       = '0;
    bus.sample_in_valid = 1'b0;
    bus.sample_tick     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    vecs++; if (bus.state_code !== 2'd0) begin errs++; $display("FAIL rst_state: got %0d exp 0", bus.state_code); end
    vecs++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_en: en=%b we=%b exp 0 0", bus.mem_en, bus.mem_we); end
    vecs++; if (bus.mem_addr !== 6'd0 || bus.mem_wdata !== 8'd0) begin errs++; $display("FAIL rst_mem_bus: addr=%0d wdata=%0h exp 0 0", bus.mem_addr, bus.mem_wdata); end
    vecs++; if (bus.sample_out !== 8'h80 || bus.sample_out_valid !== 1'b0) begin errs++; $display("FAIL rst_sample: out=%0h vld=%b exp 80 0", bus.sample_out, bus.sample_out_valid); end
    vecs++; if (bus.active_slot !== 2'd0 || bus.done !== 1'b0) begin errs++; $display("FAIL rst_slot_done: slot=%0d done=%b exp 0 0", bus.active_slot, bus.done); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_rec_play;
    logic [7:0] data [3];
    data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
    bus.slot_sel = 2'd1; bus.record_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0; bus.slot_sel = 2'd0;
    vecs++; if (bus.state_code !== 2'd1 || bus.active_slot !== 2'd1) begin errs++; $display("FAIL rp_rec_start: state=%0d slot=%0d exp 1 1", bus.state_code, bus.active_slot); end
    for (int i = 0; i < 3; i++) begin
      bus.sample_in = data[i]; bus.sample_in_valid = 1'b1;
      #1;
      vecs++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(16 + i) || bus.mem_wdata !== data[i]) begin
        errs++; $display("FAIL rp_write_%0d: en=%b we=%b addr=%0d wdata=%0h exp 1 1 %0d %0h", i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, 16 + i, data[i]); end
      @(negedge clock);
      bus.sample_in_valid = 1'b0;
      @(negedge clock);
    end
    bus.record_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0;
    vecs++; if (bus.done !== 1'b1 || bus.state_code !== 2'd0) begin errs++; $display("FAIL rp_rec_stop: done=%b state=%0d exp 1 0", bus.done, bus.state_code); end
    vecs++; if (mem_model[17] !== 8'h22) begin errs++; $display("FAIL rp_mem17: got %0h exp 22", mem_model[17]); end
    bus.slot_sel = 2'd1; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0; bus.slot_sel = 2'd3;
    vecs++; if (bus.state_code !== 2'd2 || bus.done !== 1'b0) begin errs++; $display("FAIL rp_play_start: state=%0d done=%b exp 2 0", bus.state_code, bus.done); end
    for (int i = 0; i < 3; i++) begin
      bus.sample_tick = 1'b1;
      #1;
      vecs++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 6'(16 + i)) begin
        errs++; $display("FAIL rp_read_%0d: en=%b we=%b addr=%0d exp 1 0 %0d", i, bus.mem_en, bus.mem_we, bus.mem_addr, 16 + i); end
      @(negedge clock);
      bus.sample_tick = 1'b0;
      vecs++; if (bus.sample_out_valid !== 1'b0) begin errs++; $display("FAIL rp_early_vld_%0d: got %b exp 0", i, bus.sample_out_valid); end
      @(negedge clock);
      vecs++; if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== data[i]) begin errs++; $display("FAIL rp_out_%0d: vld=%b out=%0h exp 1 %0h", i, bus.sample_out_valid, bus.sample_out, data[i]); end
      vecs++; if (bus.done !== (i == 2)) begin errs++; $display("FAIL rp_done_%0d: got %b exp %b", i, bus.done, (i == 2)); end
      @(negedge clock);
    end
    vecs++; if (bus.state_code !== 2'd0 || bus.sample_out !== 8'h80 || bus.done !== 1'b0) begin
      errs++; $display("FAIL rp_end: state=%0d out=%0h done=%b exp 0 80 0", bus.state_code, bus.sample_out, bus.done); end
  endtask

  task automatic test_full_slot;
    bus.slot_sel = 2'd3; bus.record_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.sample_in = 8'(8'hA0 + i); bus.sample_in_valid = 1'b1;
      #1;
      vecs++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(48 + i)) begin errs++; $display("FAIL full_write_%0d: we=%b addr=%0d exp 1 %0d", i, bus.mem_we, bus.mem_addr, 48 + i); end
      @(negedge clock);
      if (i < 15) begin
        vecs++; if (bus.state_code !== 2'd1) begin errs++; $display("FAIL full_early_stop_%0d: state=%0d exp 1", i, bus.state_code); end
      end
    end
    vecs++; if (bus.done !== 1'b1 || bus.state_code !== 2'd0) begin errs++; $display("FAIL full_autostop: done=%b state=%0d exp 1 0", bus.done, bus.state_code); end
    bus.sample_in = 8'hEE;
    #1;
    vecs++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL full_17th: mem_en=%b exp 0", bus.mem_en); end
    @(negedge clock);
    bus.sample_in_valid = 1'b0;
    vecs++; if (mem_model[63] !== 8'hAF || bus.done !== 1'b0) begin errs++; $display("FAIL full_mem63: mem=%0h done=%b exp af 0", mem_model[63], bus.done); end
    bus.slot_sel = 2'd3; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.sample_tick = 1'b1;
      @(negedge clock);
      bus.sample_tick = 1'b0;
      @(negedge clock);
      vecs++; if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== 8'(8'hA0 + i) || bus.done !== (i == 15)) begin
        errs++; $display("FAIL full_play_%0d: vld=%b out=%0h done=%b exp 1 %0h %b", i, bus.sample_out_valid, bus.sample_out, bus.done, 8'hA0 + i, (i == 15)); end
      @(negedge clock);
    end
    vecs++; if (bus.state_code !== 2'd0) begin errs++; $display("FAIL full_play_end: state=%0d exp 0", bus.state_code); end
  endtask

  task automatic test_pulse_edges;
    bus.slot_sel = 2'd2; bus.play_pulse = 1'b1;
    #1;
    vecs++; if (bus.mem_en !== 1'b0) begin errs++; $display("FAIL empty_mem_en: got %b exp 0", bus.mem_en); end
    @(negedge clock);
    bus.play_pulse = 1'b0;
    vecs++; if (bus.state_code !== 2'd0 || bus.done !== 1'b0) begin errs++; $display("FAIL empty_play: state=%0d done=%b exp 0 0", bus.state_code, bus.done); end
    bus.record_pulse = 1'b1; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0; bus.play_pulse = 1'b0;
    vecs++; if (bus.state_code !== 2'd1 || bus.active_slot !== 2'd2) begin errs++; $display("FAIL simul_pulses: state=%0d slot=%0d exp 1 2", bus.state_code, bus.active_slot); end
    bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    vecs++; if (bus.state_code !== 2'd1 || bus.done !== 1'b0) begin errs++; $display("FAIL play_in_rec: state=%0d done=%b exp 1 0", bus.state_code, bus.done); end
    bus.record_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0;
    vecs++; if (bus.done !== 1'b1 || bus.state_code !== 2'd0) begin errs++; $display("FAIL zero_len_stop: done=%b state=%0d exp 1 0", bus.done, bus.state_code); end
    bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    vecs++; if (bus.state_code !== 2'd0) begin errs++; $display("FAIL zero_len_play: state=%0d exp 0", bus.state_code); end
  endtask

  task automatic test_stop_inflight;
    bus.slot_sel = 2'd1; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    bus.sample_tick = 1'b1;
    @(negedge clock);
    bus.sample_tick = 1'b0; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    vecs++; if (bus.sample_out_valid !== 1'b0 || bus.sample_out !== 8'h80) begin errs++; $display("FAIL inflight_out: vld=%b out=%0h exp 0 80", bus.sample_out_valid, bus.sample_out); end
    vecs++; if (bus.done !== 1'b1 || bus.state_code !== 2'd0) begin errs++; $display("FAIL inflight_stop: done=%b state=%0d exp 1 0", bus.done, bus.state_code); end
    @(negedge clock);
    vecs++; if (bus.sample_out_valid !== 1'b0 || bus.done !== 1'b0) begin errs++; $display("FAIL inflight_late: vld=%b done=%b exp 0 0", bus.sample_out_valid, bus.done); end
  endtask

  task automatic test_reset_mid_rec;
    bus.slot_sel = 2'd0; bus.record_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sample_in = 8'(8'h50 + i); bus.sample_in_valid = 1'b1;
      @(negedge clock);
    end
    #1;
    vecs++; if (bus.mem_we !== 1'b1) begin errs++; $display("FAIL mid_rec_we: got %b exp 1", bus.mem_we); end
    reset = 1'b0;
    #1;
    vecs++; if (bus.mem_we !== 1'b0 || bus.mem_en !== 1'b0 || bus.state_code !== 2'd0) begin
      errs++; $display("FAIL async_reset: we=%b en=%b state=%0d exp 0 0 0", bus.mem_we, bus.mem_en, bus.state_code); end
    @(negedge clock);
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b exp 0", bus.done); end
    reset = 1'b1;
    bus.sample_in_valid = 1'b0;
    @(negedge clock);
    bus.slot_sel = 2'd0; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    vecs++; if (bus.state_code !== 2'd0 || bus.done !== 1'b0) begin errs++; $display("FAIL post_reset_play: state=%0d done=%b exp 0 0", bus.state_code, bus.done); end
  endtask

  task automatic test_stop_with_sample;
    logic [7:0] data [3];
    data[0] = 8'hC1; data[1] = 8'hC2; data[2] = 8'hC3;
    bus.slot_sel = 2'd2; bus.record_pulse = 1'b1;
    @(negedge clock);
    bus.record_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample_in = data[i]; bus.sample_in_valid = 1'b1;
      bus.record_pulse = (i == 2);
      #1;
      vecs++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'(32 + i)) begin errs++; $display("FAIL coinc_write_%0d: we=%b addr=%0d exp 1 %0d", i, bus.mem_we, bus.mem_addr, 32 + i); end
      @(negedge clock);
    end
    bus.sample_in_valid = 1'b0; bus.record_pulse = 1'b0;
    vecs++; if (bus.done !== 1'b1 || bus.state_code !== 2'd0 || mem_model[34] !== 8'hC3) begin
      errs++; $display("FAIL coinc_stop: done=%b state=%0d mem34=%0h exp 1 0 c3", bus.done, bus.state_code, mem_model[34]); end
    bus.slot_sel = 2'd2; bus.play_pulse = 1'b1;
    @(negedge clock);
    bus.play_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sample_tick = 1'b1;
      @(negedge clock);
      bus.sample_tick = 1'b0;
      @(negedge clock);
      vecs++; if (bus.sample_out_valid !== 1'b1 || bus.sample_out !== data[i] || bus.done !== (i == 2)) begin
        errs++; $display("FAIL coinc_play_%0d: vld=%b out=%0h done=%b exp 1 %0h %b", i, bus.sample_out_valid, bus.sample_out, bus.done, data[i], (i == 2)); end
      @(negedge clock);
    end
    vecs++; if (bus.sample_out !== 8'h80 || bus.state_code !== 2'd0) begin errs++; $display("FAIL coinc_end: out=%0h state=%0d exp 80 0", bus.sample_out, bus.state_code); end
  endtask

  initial begin
    test_reset();
    test_rec_play();
    test_full_slot();
    test_pulse_edges();
    test_stop_inflight();
    test_reset_mid_rec();
    test_stop_with_sample();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Sequences the shared sample memory for the voice recorder: writes decimated microphone samples during record and reads them back at sample rate during playback.
- Memory is split into NUM_SLOTS equal slots chosen by the two slide switches.
- Keeps a per-slot recorded length and reports state and slot to the 7-segment driver.
- Sits between the button/switch conditioning logic, the PDM decimator, the single-port BRAM and the PWM audio output stage.

Parameters:
- ADDR_W, 14, total memory address width; slot offset width OFF_W = ADDR_W-2, SLOT_DEPTH = 2**OFF_W.
- DATA_W, 8, sample width.
- NUM_SLOTS, 4, fixed by 2-bit slot select; not to be overridden.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- slot_sel  in  2  {switch1, switch0}; sampled only at operation start.
- record_pulse  in  1  one-cycle pulse, debounced upstream; start/stop record.
- play_pulse  in  1  one-cycle pulse, debounced upstream; start/stop playback.
- sample_in  in  DATA_W  decimated mic sample.
- sample_in_valid  in  1  one-cycle strobe qualifying sample_in.
- sample_tick  in  1  playback-rate strobe; guaranteed spacing ≥3 cycles.
- mem_addr  out  ADDR_W  {active_slot, offset}.
- mem_wdata  out  DATA_W  write data.
- mem_en  out  1  memory enable.
- mem_we  out  1  write enable.
- mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_en with mem_we=0.
- sample_out  out  DATA_W  sample to PWM stage.
- sample_out_valid  out  1  one-cycle strobe when sample_out updates from memory.
- state_code  out  2  0 = IDLE, 1 = REC, 2 = PLAY.
- active_slot  out  2  slot latched at start.
- done  out  1  one-cycle pulse when REC or PLAY ends for any reason.

Behaviour:
- Reset (async assert, sync release): state IDLE; all slot lengths 0; offset 0; mem_en = mem_we = 0; mem_addr = 0; mem_wdata = 0; sample_out = MID (2**(DATA_W-1)); sample_out_valid = 0; state_code = 0; active_slot = 0; done = 0. Reset mid-operation aborts with no done pulse.
- IDLE:
  - record_pulse: latch slot_sel into active_slot, offset = 0, go REC.
  - Else play_pulse with len[slot_sel] ≠ 0: latch slot, offset = 0, go PLAY.
  - play_pulse on an empty slot: ignored, stay IDLE, no done.
  - Simultaneous record and play pulses: record wins.
- REC:
  - On sample_in_valid, same cycle combinationally: mem_en = mem_we = 1, addr = {slot, offset}, wdata = sample_in. Offset increments next cycle.
  - record_pulse: len[slot] = number of samples written (0 allowed); done; IDLE. If sample_in_valid is in the same cycle, that sample is written and counted first.
  - Full: the write at offset SLOT_DEPTH-1 auto-stops; len = SLOT_DEPTH (OFF_W+1 bits); done; IDLE.
  - play_pulse is ignored in REC.
- PLAY:
  - On sample_tick: mem_en = 1, mem_we = 0, addr = {slot, offset}. Next cycle, register mem_rdata into sample_out, pulse sample_out_valid, increment offset. Tick-to-valid latency is exactly 2 clock edges.
  - After the read at offset len-1 delivers, go IDLE with done; sample_out returns to MID on the following cycle.
  - play_pulse: stop immediately. Any in-flight read is discarded (no valid pulse); sample_out = MID next cycle; done.
  - record_pulse is ignored in PLAY.
- Re-recording a slot overwrites its length; other slots are untouched.
- slot_sel changes during REC/PLAY have no effect.
- mem_en is asserted only as described; the memory is never driven in IDLE.

Decomposition:
- audio_pkg:
  - state enum (IDLE, REC, PLAY) with codes 0/1/2.
  - NUM_SLOTS = 4.
  - Function mid_level(DATA_W).
- One sub-module: slot_len_table, a 4×(OFF_W+1) register file with async active-low reset. It has one write port (slot, len, we) and one combinational read port (slot), used both for the empty check and for the PLAY end compare.

Test Plan (ADDR_W = 6, SLOT_DEPTH = 16, DATA_W = 8):
- Slot 1 record → play: record 3 samples (0x11, 0x22, 0x33) on slot 1, then record_pulse → writes at addresses 16, 17, 18; done; len[1] = 3. Play slot 1 with 3 ticks → sample_out 0x11, 0x22, 0x33, each 2 edges after its tick; then done, state 0, sample_out 0x80.
- Full-slot auto-stop: on slot 3, 16 sample_in_valid strobes → writes at 48..63; auto-stop; len = 16; done; a 17th strobe causes no write.
- Edge cases on pulses:
  - play_pulse on empty slot 2 → state stays 0, no mem_en, no done.
  - Simultaneous record and play pulse in IDLE → state_code = 1.
- Stop with read in flight: play_pulse one cycle after a sample_tick → no sample_out_valid pulse; sample_out = 0x80; done.
- Reset mid-REC: assert reset after 5 writes → mem_we drops without waiting for a clock edge; len[0] = 0; a subsequent play on slot 0 is ignored.
- Stop coincident with sample: record stop pulse in the same cycle as sample_in_valid → sample written; len includes it.
